// File: rtl/dw_conv_pkg.sv
// rtl/dw_conv_pkg.sv - shared widths, weight-load FSM encoding and requantize helpers
package dw_conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } wt_state_e;

   // Working width for requantization; wide enough that the rounding add never wraps
   localparam int REQ_W = 32;
   localparam logic signed [REQ_W-1:0] REQ_ONE = 1;

   // Nine products of two DATA_WIDTH values plus a 2*DATA_WIDTH bias cannot overflow this
   function automatic int acc_width(input int data_width);
      return 2 * data_width + 5;
   endfunction

   // Round half up, then arithmetic shift right
   function automatic logic signed [REQ_W-1:0] round_shift(input logic signed [REQ_W-1:0] v,
                                                           input logic [4:0] sh);
      logic signed [REQ_W-1:0] r;
      r = v;
      if (sh != 5'd0) r = v + (REQ_ONE <<< (sh - 5'd1));
      return r >>> sh;
   endfunction

   // ReLU is a floor of zero applied ahead of the signed saturation range
   function automatic logic signed [REQ_W-1:0] saturate(input logic signed [REQ_W-1:0] v,
                                                        input bit relu, input int dw);
      logic signed [REQ_W-1:0] hi;
      logic signed [REQ_W-1:0] lo;
      hi = (REQ_ONE <<< (dw - 1)) - REQ_ONE;
      lo = relu ? '0 : -(REQ_ONE <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/dw_mac9.sv
// rtl/dw_mac9.sv - one depthwise channel: nine signed products (S1) and bias-added sum (S2)
module dw_mac9 #(
   parameter int DATA_WIDTH     = 8,
   parameter int IN_CHANNEL_NUM = 9,
   parameter int ACC_WIDTH      = 21
) (
   input  logic                                 clk_i,
   input  logic                                 s1_en_i,
   input  logic                                 s2_en_i,
   input  logic [IN_CHANNEL_NUM*DATA_WIDTH-1:0] win_i,
   input  logic [IN_CHANNEL_NUM*DATA_WIDTH-1:0] wt_i,
   input  logic [2*DATA_WIDTH-1:0]              bias_i,
   output logic signed [ACC_WIDTH-1:0]          acc_o
);
   localparam int PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0]        prod_q [IN_CHANNEL_NUM];
   logic signed [PW-1:0]        bias_q;
   logic signed [ACC_WIDTH-1:0] sum_d;
   logic signed [ACC_WIDTH-1:0] acc_q;

   // S1: capture products and bias so a later weight reload cannot disturb this beat
   always_ff @(posedge clk_i) begin
      if (s1_en_i) begin
         for (int t = 0; t < IN_CHANNEL_NUM; t++) begin
            prod_q[t] <= PW'($signed(win_i[t*DATA_WIDTH +: DATA_WIDTH]))
                       * PW'($signed(wt_i[t*DATA_WIDTH +: DATA_WIDTH]));
         end
         bias_q <= bias_i;
      end
   end

   // S2 adder tree: sign-extended products and bias summed at accumulator width
   always_comb begin
      sum_d = ACC_WIDTH'(bias_q);
      for (int t = 0; t < IN_CHANNEL_NUM; t++) begin
         sum_d = sum_d + ACC_WIDTH'(prod_q[t]);
      end
   end

   // S2 register
   always_ff @(posedge clk_i) begin
      if (s2_en_i) acc_q <= sum_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/dw_conv_mac_array.sv
// rtl/dw_conv_mac_array.sv - depthwise 3x3 MAC array with weight load FSM and int8 requantize
module dw_conv_mac_array
   import dw_conv_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int IN_CHANNEL_NUM  = 9,
   parameter int OUT_CHANNEL_NUM = 18,
   parameter int RELU_EN         = 1
) (
   input  logic                                                 clk,
   input  logic                                                 rstn,
   input  logic [OUT_CHANNEL_NUM*IN_CHANNEL_NUM*DATA_WIDTH-1:0] win_in,
   input  logic                                                 valid_in,
   input  logic [4:0]                                           quant_shift,
   input  logic                                                 wt_load_start,
   input  logic [IN_CHANNEL_NUM*DATA_WIDTH-1:0]                 wt_in,
   input  logic [2*DATA_WIDTH-1:0]                              bias_in,
   input  logic                                                 wt_valid,
   output logic                                                 wt_ready,
   output logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0]                data_out,
   output logic                                                 valid_out,
   output logic                                                 drop_err
);
   localparam int ACC_WIDTH = acc_width(DATA_WIDTH);
   localparam int WW        = IN_CHANNEL_NUM * DATA_WIDTH;
   localparam int CNT_W     = (OUT_CHANNEL_NUM > 1) ? $clog2(OUT_CHANNEL_NUM) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_CHANNEL_NUM - 1);

   wt_state_e                            state_q, state_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic                                 load_we;
   logic                                 drop_err_q, drop_err_d;
   logic                                 accept;
   logic                                 v1_q, v2_q, valid_out_q;
   logic [4:0]                           shift1_q, shift2_q;
   logic [WW-1:0]                        wt_q   [OUT_CHANNEL_NUM];
   logic [2*DATA_WIDTH-1:0]              bias_q [OUT_CHANNEL_NUM];
   logic signed [ACC_WIDTH-1:0]          acc    [OUT_CHANNEL_NUM];
   logic [OUT_CHANNEL_NUM*DATA_WIDTH-1:0] data_out_q, data_out_d;

   assign wt_ready = (state_q == ST_READY);
   assign accept   = valid_in & wt_ready;

   // Weight-load FSM: a start always restarts at channel 0; beats outside LOAD are ignored
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_we = 1'b0;
      if (wt_load_start) begin
         state_d = ST_LOAD;
         cnt_d   = '0;
      end else if (state_q == ST_LOAD && wt_valid) begin
         load_we = 1'b1;
         if (cnt_q == CNT_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      drop_err_d = wt_load_start ? 1'b0 : (drop_err_q | (valid_in & ~wt_ready));
   end

   // Control state, valid pipeline and output register; reset flushes everything in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         drop_err_q  <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         valid_out_q <= 1'b0;
         data_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drop_err_q  <= drop_err_d;
         v1_q        <= accept;
         v2_q        <= v1_q;
         valid_out_q <= v2_q;
         if (v2_q) data_out_q <= data_out_d;
      end
   end

   // Weight/bias file and shift pipeline: always written before they are consumed
   always_ff @(posedge clk) begin
      if (load_we) begin
         wt_q[cnt_q]   <= wt_in;
         bias_q[cnt_q] <= bias_in;
      end
      if (accept) shift1_q <= quant_shift;
      if (v1_q)   shift2_q <= shift1_q;
   end

   for (genvar c = 0; c < OUT_CHANNEL_NUM; c++) begin : g_ch
      dw_mac9 #(
         .DATA_WIDTH    (DATA_WIDTH),
         .IN_CHANNEL_NUM(IN_CHANNEL_NUM),
         .ACC_WIDTH     (ACC_WIDTH)
      ) u_mac (
         .clk_i  (clk),
         .s1_en_i(accept),
         .s2_en_i(v1_q),
         .win_i  (win_in[c*WW +: WW]),
         .wt_i   (wt_q[c]),
         .bias_i (bias_q[c]),
         .acc_o  (acc[c])
      );
   end

   // S3 requantize: round, shift, optional ReLU floor, saturate to the output width
   always_comb begin
      data_out_d = '0;
      for (int c = 0; c < OUT_CHANNEL_NUM; c++) begin
         data_out_d[c*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(saturate(round_shift(REQ_W'(acc[c]), shift2_q), RELU_EN != 0, DATA_WIDTH));
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_dw_conv_mac_array.sv
// tb/tb_dw_conv_mac_array.sv - scoreboard bench for dw_conv_mac_array (ReLU and linear instances)
module tb_dw_conv_mac_array;
   localparam int DW    = 8;
   localparam int TAPS  = 9;
   localparam int CH    = 18;
   localparam int WIN_W = CH * TAPS * DW;
   localparam int OUT_W = CH * DW;

   logic               clk  = 1'b0;
   logic               rstn = 1'b1;
   logic [WIN_W-1:0]   win_in;
   logic               valid_in;
   logic [4:0]         quant_shift;
   logic               wt_load_start;
   logic [TAPS*DW-1:0] wt_in;
   logic [2*DW-1:0]    bias_in;
   logic               wt_valid;
   logic               wt_ready_r, wt_ready_l, valid_out_r, valid_out_l, drop_err_r, drop_err_l;
   logic [OUT_W-1:0]   data_out_r, data_out_l;

   always #5 clk = ~clk;

   dw_conv_mac_array #(.DATA_WIDTH(DW), .IN_CHANNEL_NUM(TAPS), .OUT_CHANNEL_NUM(CH), .RELU_EN(1)) u_dut_relu (
      .clk(clk), .rstn(rstn), .win_in(win_in), .valid_in(valid_in), .quant_shift(quant_shift),
      .wt_load_start(wt_load_start), .wt_in(wt_in), .bias_in(bias_in), .wt_valid(wt_valid),
      .wt_ready(wt_ready_r), .data_out(data_out_r), .valid_out(valid_out_r), .drop_err(drop_err_r));

   dw_conv_mac_array #(.DATA_WIDTH(DW), .IN_CHANNEL_NUM(TAPS), .OUT_CHANNEL_NUM(CH), .RELU_EN(0)) u_dut_lin (
      .clk(clk), .rstn(rstn), .win_in(win_in), .valid_in(valid_in), .quant_shift(quant_shift),
      .wt_load_start(wt_load_start), .wt_in(wt_in), .bias_in(bias_in), .wt_valid(wt_valid),
      .wt_ready(wt_ready_l), .data_out(data_out_l), .valid_out(valid_out_l), .drop_err(drop_err_l));

   typedef struct {
      int               stamp;
      logic [OUT_W-1:0] relu;
      logic [OUT_W-1:0] lin;
   } exp_t;

   exp_t             sb_q[$];
   int               cyc     = 0;
   int               n_tests = 0;
   int               n_fail  = 0;
   int               mw [CH][TAPS];
   int               mb [CH];
   bit               model_ready = 1'b0;
   bit               exp_drop    = 1'b0;
   bit               mon_en      = 1'b0;
   logic [OUT_W-1:0] last_r = '0;
   logic [OUT_W-1:0] last_l = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [OUT_W-1:0] model(input logic [WIN_W-1:0] w, input int sh, input bit relu);
      logic [OUT_W-1:0] r;
      longint           acc;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         acc = longint'(mb[c]);
         for (int t = 0; t < TAPS; t++)
            acc += longint'($signed(w[(c*TAPS+t)*DW +: DW])) * longint'(mw[c][t]);
         if (sh > 0) acc += longint'(1) << (sh - 1);
         acc = acc >>> sh;
         if (relu && acc < 0) acc = 0;
         if (acc > 127)  acc = 127;
         if (acc < -128) acc = -128;
         r[c*DW +: DW] = acc[DW-1:0];
      end
      return r;
   endfunction

   function automatic logic [WIN_W-1:0] fill(input int v);
      logic [WIN_W-1:0] w;
      for (int i = 0; i < CH * TAPS; i++) w[i*DW +: DW] = v[DW-1:0];
      return w;
   endfunction

   function automatic logic [WIN_W-1:0] tap0_win(input int v);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int c = 0; c < CH; c++) w[c*TAPS*DW +: DW] = v[DW-1:0];
      return w;
   endfunction

   function automatic logic [WIN_W-1:0] rand_win();
      logic [WIN_W-1:0] w;
      for (int i = 0; i < CH * TAPS; i++) w[i*DW +: DW] = DW'($urandom);
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_beat(input logic [WIN_W-1:0] w, input logic [4:0] sh, input bit st);
      exp_t e;
      win_in        = w;
      quant_shift   = sh;
      valid_in      = 1'b1;
      wt_load_start = st;
      if (model_ready) begin
         e.stamp = cyc + 3;
         e.relu  = model(w, int'(sh), 1'b1);
         e.lin   = model(w, int'(sh), 1'b0);
         sb_q.push_back(e);
      end else begin
         exp_drop = 1'b1;
      end
      if (st) exp_drop = 1'b0;
      step();
      valid_in      = 1'b0;
      wt_load_start = 1'b0;
      if (st) model_ready = 1'b0;
   endtask

   task automatic load_body(input int mode);
      for (int c = 0; c < CH; c++) begin
         for (int t = 0; t < TAPS; t++) begin
            case (mode)
               0:       mw[c][t] = 1;
               1:       mw[c][t] = 127;
               2:       mw[c][t] = (t == 0) ? 1 : 0;
               default: mw[c][t] = int'($urandom_range(255)) - 128;
            endcase
            wt_in[t*DW +: DW] = mw[c][t][DW-1:0];
         end
         mb[c]    = (mode == 3) ? int'($urandom_range(65535)) - 32768 : 0;
         bias_in  = mb[c][2*DW-1:0];
         wt_valid = 1'b1;
         chk("ready_during_load", 160'(wt_ready_r), 160'(0));
         step();
      end
      wt_valid    = 1'b0;
      model_ready = 1'b1;
      chk("ready_after_load", 160'({wt_ready_r, wt_ready_l}), 160'(2'b11));
   endtask

   task automatic load_weights(input int mode);
      wt_load_start = 1'b1;
      model_ready   = 1'b0;
      exp_drop      = 1'b0;
      step();
      wt_load_start = 1'b0;
      chk("drop_after_start", 160'(drop_err_r), 160'(exp_drop));
      load_body(mode);
   endtask

   // Scoreboard: each expected beat must appear exactly at its stamp; otherwise output holds
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (sb_q.size() > 0 && sb_q[0].stamp <= cyc) begin
            e = sb_q.pop_front();
            chk("valid_out", 160'({valid_out_r, valid_out_l}), 160'(2'b11));
            chk("data_relu", 160'(data_out_r), 160'(e.relu));
            chk("data_lin", 160'(data_out_l), 160'(e.lin));
            last_r = e.relu;
            last_l = e.lin;
         end else begin
            chk("idle_valid", 160'({valid_out_r, valid_out_l}), 160'(0));
            chk("hold_relu", 160'(data_out_r), 160'(last_r));
            chk("hold_lin", 160'(data_out_l), 160'(last_l));
         end
      end
   end

   initial begin
      win_in = '0; valid_in = 1'b0; quant_shift = '0; wt_load_start = 1'b0;
      wt_in = '0; bias_in = '0; wt_valid = 1'b0;
      #1 rstn = 1'b0;
      step();
      step();
      chk("rst_wt_ready", 160'({wt_ready_r, wt_ready_l}), 160'(0));
      chk("rst_valid_out", 160'({valid_out_r, valid_out_l}), 160'(0));
      chk("rst_drop_err", 160'({drop_err_r, drop_err_l}), 160'(0));
      chk("rst_data_relu", 160'(data_out_r), 160'(0));
      chk("rst_data_lin", 160'(data_out_l), 160'(0));
      rstn   = 1'b1;
      mon_en = 1'b1;
      step();

      // data before any load is dropped and flagged
      send_beat(fill(10), 5'd0, 1'b0);
      idle(4);
      chk("drop_set", 160'({drop_err_r, drop_err_l}), 160'({exp_drop, exp_drop}));

      // unit weights: 9 taps of 10 -> 90; a wt_valid in READY must not change weights
      load_weights(0);
      send_beat(fill(10), 5'd0, 1'b0);
      wt_in = '1; bias_in = '1; wt_valid = 1'b1;
      step();
      wt_valid = 1'b0;
      send_beat(fill(10), 5'd0, 1'b0);
      idle(4);

      // saturation at both ends
      load_weights(1);
      send_beat(fill(127), 5'd0, 1'b0);
      send_beat(fill(-128), 5'd0, 1'b0);
      idle(4);

      // round half up on +/-5 with shift 1, plus the largest shift
      load_weights(2);
      send_beat(tap0_win(5), 5'd1, 1'b0);
      send_beat(tap0_win(-5), 5'd1, 1'b0);
      send_beat(tap0_win(-128), 5'd20, 1'b0);
      idle(4);

      // 100 back-to-back random beats; the last one carries a reload start (old weights)
      load_weights(3);
      for (int i = 0; i < 100; i++)
         send_beat(rand_win(), 5'($urandom_range(20)), i == 99);
      load_body(3);
      for (int i = 0; i < 20; i++)
         send_beat(rand_win(), 5'($urandom_range(20)), 1'b0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++)
         send_beat(rand_win(), 5'($urandom_range(20)), 1'b0);
      rstn = 1'b0;
      #1;
      chk("midrst_valid_out", 160'({valid_out_r, valid_out_l}), 160'(0));
      chk("midrst_wt_ready", 160'({wt_ready_r, wt_ready_l}), 160'(0));
      sb_q.delete();
      last_r      = '0;
      last_l      = '0;
      model_ready = 1'b0;
      exp_drop    = 1'b0;
      step();
      rstn = 1'b1;
      send_beat(rand_win(), 5'd0, 1'b0);
      idle(4);
      chk("drop_after_rst", 160'({drop_err_r, drop_err_l}), 160'({exp_drop, exp_drop}));
      idle(2);
      chk("sb_empty", 160'(sb_q.size()), 160'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
